dual_port_ram_be: RTL

DUAL_PORT_RAM_BE -- requirements
Module: dual_port_ram_be

---
 rtl/dual_port_ram_pkg.sv | 12 +
 rtl/dual_port_ram_port.sv | 65 ++++++
 rtl/dual_port_ram_be.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dual_port_ram_pkg.sv
// Shared constants and state type for the byte-enable dual-port RAM.
package dual_port_ram_pkg;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/dual_port_ram_port.sv
// Per-port read-data shaping (write-first lane merge) and optional output register stage.
module dual_port_ram_port
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_W     = 8,
    parameter int RD_MODE    = RD_FIRST,
    parameter int OUT_REG    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        rd_word,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [DATA_WIDTH/BYTE_W-1:0] wr_lanes,
    input  logic                         valid_in,
    input  logic                         coll_in,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         valid,
    output logic                         collision
);

    localparam int NB = DATA_WIDTH / BYTE_W;

    logic [DATA_WIDTH-1:0] word_s1;
    logic [DATA_WIDTH-1:0] dout_d, dout_q;
    logic                  valid_d, valid_q;
    logic                  coll_d, coll_q;

    // rd_word is the array word before this access's own write; write-first overlays it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        word_s1 = rd_word;
        if (RD_MODE == WR_FIRST) begin
            for (int l = 0; l < NB; l++) begin
                if (wr_lanes[l]) begin
                    word_s1[l*BYTE_W +: BYTE_W] = wr_data[l*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_comb begin
        dout_d  = valid_in ? word_s1 : dout_q;
        valid_d = valid_in;
        coll_d  = coll_in;
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample together.
        if (rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            coll_q  <= coll_d;
        end
    end

    assign dout      = (OUT_REG != 0) ? dout_q  : word_s1;
    assign valid     = (OUT_REG != 0) ? valid_q : valid_in;
    assign collision = (OUT_REG != 0) ? coll_q  : coll_in;

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with per-byte write enables, zero-fill initialisation and collision flag.
module dual_port_ram_be
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 256,
    parameter int BYTE_W         = 8,
    parameter int RD_MODE        = RD_FIRST,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_a,
    input  logic                         en_b,
    input  logic [DATA_WIDTH/BYTE_W-1:0] we_a,
    input  logic [DATA_WIDTH/BYTE_W-1:0] we_b,
    input  logic [$clog2(DEPTH)-1:0]     addr_a,
    input  logic [$clog2(DEPTH)-1:0]     addr_b,
    input  logic [DATA_WIDTH-1:0]        din_a,
    input  logic [DATA_WIDTH-1:0]        din_b,
    output logic [DATA_WIDTH-1:0]        dout_a,
    output logic [DATA_WIDTH-1:0]        dout_b,
    output logic                         valid_a,
    output logic                         valid_b,
    output logic                         busy,
    output logic                         collision
);

    localparam int NB = DATA_WIDTH / BYTE_W;
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e          state_q, state_d;
    logic [AW-1:0]   init_cnt_q, init_cnt_d;
    logic            clr_en;

    logic            in_range_a, in_range_b;
    logic            acc_a, acc_b, wr_a, wr_b;
    logic            valid_a_s1_d, valid_a_s1_q, valid_b_s1_d, valid_b_s1_q;
    logic            coll_s1_d, coll_s1_q;
    logic [NB-1:0]   wr_lanes_a_d, wr_lanes_a_q, wr_lanes_b_d, wr_lanes_b_q;
    logic [DATA_WIDTH-1:0] wr_data_a_d, wr_data_a_q, wr_data_b_d, wr_data_b_q;
    logic [DATA_WIDTH-1:0] rd_word_a_q, rd_word_b_q;
    logic            coll_out_a, coll_out_b;

    assign busy = rst | (state_q == INIT);

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        clr_en     = 1'b0;
        case (state_q)
            INIT: begin
                if (CLEAR_ON_RESET != 0) begin
                    clr_en = 1'b1;
                    if (init_cnt_q == AW'(DEPTH - 1)) state_d = RUN;
                    else                              init_cnt_d = init_cnt_q + 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: ;
        endcase
        if (rst) begin
            state_d    = INIT;
            init_cnt_d = '0;
            clr_en     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Addresses past DEPTH only exist when DEPTH is not a power of two.
    if (DEPTH == (1 << AW)) begin : g_pow2
        assign in_range_a = 1'b1;
        assign in_range_b = 1'b1;
    end else begin : g_npow2
        assign in_range_a = ({1'b0, addr_a} < (AW+1)'(DEPTH));
        assign in_range_b = ({1'b0, addr_b} < (AW+1)'(DEPTH));
    end

    always_comb begin
        acc_a        = en_a & ~busy;
        acc_b        = en_b & ~busy;
        wr_a         = acc_a & (|we_a) & in_range_a;
        wr_b         = acc_b & (|we_b) & in_range_b;
        valid_a_s1_d = acc_a;
        valid_b_s1_d = acc_b;
        coll_s1_d    = acc_a & acc_b & (addr_a == addr_b) & ((|we_a) | (|we_b));
        wr_lanes_a_d = acc_a ? (wr_a ? we_a : '0) : wr_lanes_a_q;
        wr_lanes_b_d = acc_b ? (wr_b ? we_b : '0) : wr_lanes_b_q;
        wr_data_a_d  = acc_a ? din_a : wr_data_a_q;
        wr_data_b_d  = acc_b ? din_b : wr_data_b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_a_s1_q <= 1'b0;
            valid_b_s1_q <= 1'b0;
            coll_s1_q    <= 1'b0;
            wr_lanes_a_q <= '0;
            wr_lanes_b_q <= '0;
            wr_data_a_q  <= '0;
            wr_data_b_q  <= '0;
        end else begin
            valid_a_s1_q <= valid_a_s1_d;
            valid_b_s1_q <= valid_b_s1_d;
            coll_s1_q    <= coll_s1_d;
            wr_lanes_a_q <= wr_lanes_a_d;
            wr_lanes_b_q <= wr_lanes_b_d;
            wr_data_a_q  <= wr_data_a_d;
            wr_data_b_q  <= wr_data_b_d;
        end
    end

    // Port A lanes are written last so they win any lane both ports enable.
    always_ff @(posedge clk) begin
        // NOTE: the array itself is never reset; only INIT clears it, keeping it block-RAM friendly.
        if (clr_en) mem[init_cnt_q] <= '0;
        for (int l = 0; l < NB; l++) begin
            if (wr_b && we_b[l]) mem[addr_b][l*BYTE_W +: BYTE_W] <= din_b[l*BYTE_W +: BYTE_W];
        end
        for (int l = 0; l < NB; l++) begin
            if (wr_a && we_a[l]) mem[addr_a][l*BYTE_W +: BYTE_W] <= din_a[l*BYTE_W +: BYTE_W];
        end
        if (rst)        rd_word_a_q <= '0;
        else if (acc_a) rd_word_a_q <= in_range_a ? mem[addr_a] : '0;
        if (rst)        rd_word_b_q <= '0;
        else if (acc_b) rd_word_b_q <= in_range_b ? mem[addr_b] : '0;
    end

    dual_port_ram_port #(
        .DATA_WIDTH(DATA_WIDTH), .BYTE_W(BYTE_W), .RD_MODE(RD_MODE), .OUT_REG(OUT_REG)
    ) u_port_a (
        .clk(clk), .rst(rst), .rd_word(rd_word_a_q), .wr_data(wr_data_a_q),
        .wr_lanes(wr_lanes_a_q), .valid_in(valid_a_s1_q), .coll_in(coll_s1_q),
        .dout(dout_a), .valid(valid_a), .collision(coll_out_a)
    );

    dual_port_ram_port #(
        .DATA_WIDTH(DATA_WIDTH), .BYTE_W(BYTE_W), .RD_MODE(RD_MODE), .OUT_REG(OUT_REG)
    ) u_port_b (
        .clk(clk), .rst(rst), .rd_word(rd_word_b_q), .wr_data(wr_data_b_q),
        .wr_lanes(wr_lanes_b_q), .valid_in(valid_b_s1_q), .coll_in(coll_s1_q),
        .dout(dout_b), .valid(valid_b), .collision(coll_out_b)
    );

    assign collision = coll_out_a | coll_out_b;

endmodule
